// File: rtl/usb_host_scheduler_pkg.sv
// Shared USB host scheduler definitions: onehot transaction type encodings
// ({SETUP,OUT,IN}) and the slot-to-type helper.
package usb_host_scheduler_pkg;

  localparam logic [2:0] TXN_NONE  = 3'b000;
  localparam logic [2:0] TXN_SETUP = 3'b100;
  localparam logic [2:0] TXN_OUT   = 3'b010;
  localparam logic [2:0] TXN_IN    = 3'b001;

  // Slots interleave OUT0,IN0,OUT1,IN1,...; an odd slot index is an IN poll.
  function automatic logic [2:0] slotTxnType(input logic isInSlot);
    return isInSlot ? TXN_IN : TXN_OUT;
  endfunction

endpackage

// File: rtl/usb_host_scheduler_rr_arbiter.sv
// Round-robin arbiter over N request slots: onehot grant searched from the
// pointer, pointer moves past the granted slot only when the grant is accepted.
module rrArbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          update,
  input  logic [IW-1:0] updIdx,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grantIdx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  always_comb begin
    // NOTE: every variable gets a default before the search so no latch is inferred.
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = IW'(idx);
      end
    end
  end

  // ptr is the highest-priority slot for the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (updIdx == IW'(N - 1)) ? '0 : updIdx + IW'(1);
    end
  end

endmodule

// File: rtl/usb_host_scheduler.sv
// USB host transaction scheduler: picks SETUP / OUT / periodic IN work and
// hands one transaction at a time to the host transactor via valid/ready.
module usb_host_scheduler
  import usb_host_scheduler_pkg::*;
#(
  parameter int N_ENDP         = 2,
  parameter int POLL_CYCLES    = 4096,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              i_clk_48MHz,
  input  logic              i_rst_n,
  input  logic [6:0]        i_devAddr,
  input  logic              i_setupReq,
  input  logic [N_ENDP-1:0] i_outReq,
  input  logic [N_ENDP-1:0] i_inEnable,
  output logic              o_txnValid,
  input  logic              i_txnReady,
  output logic [2:0]        o_txnType,
  output logic [6:0]        o_txnAddr,
  output logic [3:0]        o_txnEndp,
  input  logic [2:0]        i_txnType,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam int N_SLOTS = 2 * N_ENDP;
  localparam int SLOT_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int POLL_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} schedState_e;

  schedState_e       state;
  logic [N_SLOTS-1:0] slotReq;
  logic [N_SLOTS-1:0] grant;
  logic [SLOT_W-1:0]  grantIdx;
  logic [SLOT_W-1:0]  slotReg;
  logic               isSetup;
  logic [TO_W-1:0]    toCnt;
  logic [POLL_W-1:0]  pollCnt [N_ENDP];
  logic [N_ENDP-1:0]  inPending;
  logic [N_ENDP-1:0]  inAccept;
  logic               accept;
  logic               timeoutHit;
  logic               txnActive;

  assign accept     = (state == ISSUE) && o_txnValid && i_txnReady;
  assign timeoutHit = (toCnt == TO_LAST);
  assign txnActive  = (i_txnType != TXN_NONE);

  always_comb begin
    slotReq  = '0;
    inAccept = '0;
    for (int e = 0; e < N_ENDP; e++) begin
      slotReq[2*e]   = i_outReq[e];
      slotReq[2*e+1] = inPending[e];
      inAccept[e]    = accept && !isSetup && slotReg[0] && (int'(slotReg >> 1) == e);
    end
  end

  rrArbiter #(.N(N_SLOTS)) uArb (
    .clk      (i_clk_48MHz),
    .rst_n    (i_rst_n),
    .req      (slotReq),
    .update   (accept && !isSetup),
    .updIdx   (slotReg),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  // Poll counters saturate at POLL_LAST with inPending set until the IN is accepted.
  always_ff @(posedge i_clk_48MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the counter array is a few flops, not a RAM, so it takes the async reset too.
      for (int e = 0; e < N_ENDP; e++) pollCnt[e] <= '0;
      inPending <= '0;
    end else begin
      for (int e = 0; e < N_ENDP; e++) begin
        if (!i_inEnable[e] || inAccept[e]) begin
          pollCnt[e]   <= '0;
          inPending[e] <= 1'b0;
        end else if (pollCnt[e] == POLL_LAST) begin
          inPending[e] <= 1'b1;
        end else begin
          pollCnt[e] <= pollCnt[e] + POLL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk_48MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_txnValid <= 1'b0;
      o_txnType  <= TXN_NONE;
      o_txnAddr  <= '0;
      o_txnEndp  <= '0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      toCnt      <= '0;
      slotReg    <= '0;
      isSetup    <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every branch sees pre-edge values.
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          toCnt <= '0;
          if (!txnActive && (i_setupReq || (|grant))) begin
            state      <= ISSUE;
            o_busy     <= 1'b1;
            o_txnValid <= 1'b1;
            o_txnAddr  <= i_devAddr;
            if (i_setupReq) begin
              isSetup   <= 1'b1;
              o_txnType <= TXN_SETUP;
              o_txnEndp <= '0;
            end else begin
              isSetup   <= 1'b0;
              slotReg   <= grantIdx;
              o_txnType <= slotTxnType(grantIdx[0]);
              o_txnEndp <= 4'(grantIdx >> 1);
            end
          end
        end
        ISSUE: begin
          if (accept || timeoutHit || txnActive) begin
            o_txnValid <= 1'b0;
            o_txnType  <= TXN_NONE;
            o_txnAddr  <= '0;
            o_txnEndp  <= '0;
            toCnt      <= '0;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
          if (accept) begin
            state <= WAIT_START;
          end else if (timeoutHit || txnActive) begin
            // Abandon the offer; pending requests stay and are re-arbitrated.
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_timeout <= timeoutHit;
          end
        end
        WAIT_START: begin
          if (txnActive) begin
            state <= WAIT_DONE;
            toCnt <= '0;
          end else if (timeoutHit) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!txnActive) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (timeoutHit) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_host_scheduler.sv
// Directed bench for usb_host_scheduler: scoreboard of expected transactions,
// a simple transactor model, and per-cycle protocol assertions.
module tb_usb_host_scheduler;
  import usb_host_scheduler_pkg::*;

  typedef struct packed {
    logic [2:0] typ;
    logic [6:0] addr;
    logic [3:0] endp;
  } txnExp_t;

  logic       i_clk_48MHz;
  logic       i_rst_n;
  logic [6:0] i_devAddr;
  logic       i_setupReq;
  logic [1:0] i_outReq;
  logic [1:0] i_inEnable;
  logic       o_txnValid;
  logic       i_txnReady;
  logic [2:0] o_txnType;
  logic [6:0] o_txnAddr;
  logic [3:0] o_txnEndp;
  logic [2:0] i_txnType;
  logic       o_busy;
  logic       o_timeout;

  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      acceptCount = 0;
  int      nPushed = 0;
  txnExp_t sb [$];

  usb_host_scheduler #(.N_ENDP(2), .POLL_CYCLES(16), .TIMEOUT_CYCLES(32)) dut (
    .i_clk_48MHz (i_clk_48MHz),
    .i_rst_n     (i_rst_n),
    .i_devAddr   (i_devAddr),
    .i_setupReq  (i_setupReq),
    .i_outReq    (i_outReq),
    .i_inEnable  (i_inEnable),
    .o_txnValid  (o_txnValid),
    .i_txnReady  (i_txnReady),
    .o_txnType   (o_txnType),
    .o_txnAddr   (o_txnAddr),
    .o_txnEndp   (o_txnEndp),
    .i_txnType   (i_txnType),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial i_clk_48MHz = 1'b0;
  always #5 i_clk_48MHz = ~i_clk_48MHz;

  always @(posedge i_clk_48MHz) begin
    cyc <= cyc + 1;
    if (i_rst_n && o_txnValid && i_txnReady) acceptCount <= acceptCount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Protocol checks every cycle while out of reset.
  always @(negedge i_clk_48MHz) begin
    if (i_rst_n) begin
      check("onehot0_type", 32'($onehot0(o_txnType)), 32'd1);
      check("valid_while_active", 32'(o_txnValid && (i_txnType != 3'b000)), 32'd0);
      if (!o_txnValid) check("idle_fields_zero", 32'({o_txnType, o_txnAddr, o_txnEndp}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic pushExp(input logic [2:0] typ, input logic [3:0] endp);
    txnExp_t e;
    e.typ  = typ;
    e.addr = i_devAddr;
    e.endp = endp;
    sb.push_back(e);
    nPushed++;
  endtask

  task automatic waitValid(output int vCyc);
    int n;
    n = 0;
    while (!o_txnValid && n < 200) begin
      @(negedge i_clk_48MHz);
      n++;
    end
    check("valid_wait", 32'(o_txnValid), 32'd1);
    vCyc = cyc;
  endtask

  // Transactor model: optionally stall ready, accept, then run busy cycles.
  task automatic serve(input int readyDelay, input int busyCycles, input bit dropReq,
                       output int accCyc);
    txnExp_t e;
    int vCyc;
    waitValid(vCyc);
    e = (sb.size() > 0) ? sb[0] : '0;
    check("txn_type", 32'(o_txnType), 32'(e.typ));
    check("txn_addr", 32'(o_txnAddr), 32'(e.addr));
    check("txn_endp", 32'(o_txnEndp), 32'(e.endp));
    for (int i = 0; i < readyDelay; i++) begin
      @(negedge i_clk_48MHz);
      check("stall_valid", 32'(o_txnValid), 32'd1);
      check("stall_fields", 32'({o_txnType, o_txnAddr, o_txnEndp}), 32'(e));
    end
    i_txnReady = 1'b1;
    @(negedge i_clk_48MHz);
    accCyc = cyc;
    i_txnReady = 1'b0;
    check("valid_drop", 32'(o_txnValid), 32'd0);
    check("busy_after_accept", 32'(o_busy), 32'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    if (dropReq) begin
      if (e.typ == TXN_SETUP) i_setupReq = 1'b0;
      else if (e.typ == TXN_OUT) i_outReq[e.endp[0]] = 1'b0;
    end
    if (busyCycles > 0) begin
      i_txnType = e.typ;
      repeat (busyCycles) @(negedge i_clk_48MHz);
      i_txnType = 3'b000;
    end
  endtask

  initial begin
    int  accCyc;
    int  vCyc;
    int  toN;
    bit  sawValid;

    i_rst_n    = 1'b0;
    i_devAddr  = 7'h2A;
    i_setupReq = 1'b0;
    i_outReq   = 2'b00;
    i_inEnable = 2'b00;
    i_txnReady = 1'b0;
    i_txnType  = 3'b000;

    // Reset state
    repeat (3) @(negedge i_clk_48MHz);
    check("rst_valid", 32'(o_txnValid), 32'd0);
    check("rst_fields", 32'({o_txnType, o_txnAddr, o_txnEndp}), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk_48MHz);
    check("idle_after_release", 32'(o_valid_or_busy()), 32'd0);

    // SETUP beats OUT; then OUT0, OUT1 round-robin; first accept stalled 10 cycles
    i_setupReq = 1'b1;
    i_outReq   = 2'b11;
    pushExp(TXN_SETUP, 4'd0);
    pushExp(TXN_OUT, 4'd0);
    pushExp(TXN_OUT, 4'd1);
    @(negedge i_clk_48MHz);
    check("issue_latency", 32'(o_txnValid), 32'd1);
    check("busy_in_issue", 32'(o_busy), 32'd1);
    serve(10, 3, 1'b1, accCyc);
    serve(0, 3, 1'b1, accCyc);
    serve(0, 3, 1'b1, accCyc);

    // Timeout in WAIT_START, then the still-held OUT request is reissued
    i_outReq = 2'b10;
    pushExp(TXN_OUT, 4'd1);
    serve(0, 0, 1'b0, accCyc);
    toN = 0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge i_clk_48MHz);
      if (o_timeout) begin
        toN = n;
        break;
      end
    end
    check("timeout_delay", 32'(toN), 32'd32);
    check("timeout_busy", 32'(o_busy), 32'd0);
    check("timeout_valid", 32'(o_txnValid), 32'd0);
    @(negedge i_clk_48MHz);
    check("timeout_pulse_width", 32'(o_timeout), 32'd0);
    check("reissue_valid", 32'(o_txnValid), 32'd1);
    pushExp(TXN_OUT, 4'd1);
    serve(0, 2, 1'b1, accCyc);

    // Reset during WAIT_DONE abandons the transaction
    i_outReq = 2'b01;
    pushExp(TXN_OUT, 4'd0);
    serve(0, 0, 1'b1, accCyc);
    i_txnType = TXN_OUT;
    repeat (2) @(negedge i_clk_48MHz);
    check("busy_wait_done", 32'(o_busy), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(o_busy), 32'd0);
    check("async_rst_valid", 32'(o_txnValid), 32'd0);
    i_txnType = 3'b000;
    @(negedge i_clk_48MHz);
    i_rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (20) begin
      @(negedge i_clk_48MHz);
      if (o_txnValid) sawValid = 1'b1;
    end
    check("no_txn_after_reset", 32'(sawValid), 32'd0);
    i_outReq = 2'b10;
    pushExp(TXN_OUT, 4'd1);
    @(negedge i_clk_48MHz);
    check("post_reset_latency", 32'(o_txnValid), 32'd1);
    serve(0, 2, 1'b1, accCyc);

    // Periodic IN polling on endpoint 0 from a fresh reset
    @(negedge i_clk_48MHz);
    i_rst_n    = 1'b0;
    i_inEnable = 2'b01;
    @(negedge i_clk_48MHz);
    i_rst_n = 1'b1;
    repeat (16) @(negedge i_clk_48MHz);
    check("poll_not_early", 32'(o_txnValid), 32'd0);
    @(negedge i_clk_48MHz);
    check("poll_first_valid", 32'(o_txnValid), 32'd1);
    pushExp(TXN_IN, 4'd0);
    serve(0, 2, 1'b1, accCyc);
    for (int k = 0; k < 2; k++) begin
      waitValid(vCyc);
      check("poll_period", 32'(vCyc - accCyc), 32'd17);
      pushExp(TXN_IN, 4'd0);
      serve(0, 2, 1'b1, accCyc);
    end

    check("accept_count", 32'(acceptCount), 32'(nPushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic o_valid_or_busy();
    return o_txnValid | o_busy;
  endfunction

endmodule
